inst_mem_loader: RTL

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_pkg.sv | 33 +++
 rtl/inst_mem_blk_decode.sv | 32 +++
 rtl/inst_mem_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
// Shared constants and types for the instruction-memory loader and the
// read-side banking logic.
//   BLOCK_WORDS / NUM_BLOCKS / MEM_WORDS : memory geometry in 16-bit words
//   blk_sel_e                            : block-select index
//   load_state_e                         : loader FSM states
//   blk_onehot()                         : block index -> one-hot write enable
// -----------------------------------------------------------------------------
package inst_mem_pkg;

  localparam int BLOCK_WORDS = 65536;
  localparam int NUM_BLOCKS  = 3;
  localparam int MEM_WORDS   = BLOCK_WORDS * NUM_BLOCKS;

  typedef enum logic [1:0] {
    BLOCK0 = 2'd0,
    BLOCK1 = 2'd1,
    BLOCK2 = 2'd2
  } blk_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } load_state_e;

  function automatic logic [2:0] blk_onehot(input blk_sel_e blk);
    return 3'b001 << blk;
  endfunction

endpackage

// File: rtl/inst_mem_blk_decode.sv
// -----------------------------------------------------------------------------
// inst_mem_blk_decode
// Combinational map from a flat word address to (block index, block offset).
// Shared by the loader write path and the read-side banking.
//   addr_i   in  32  flat word address
//   blk_o    out  2  block index (BLOCK0..BLOCK2)
//   offset_o out 16  word offset within the selected block
// -----------------------------------------------------------------------------
module inst_mem_blk_decode
  import inst_mem_pkg::*;
(
  input  logic [31:0] addr_i,
  output blk_sel_e    blk_o,
  output logic [15:0] offset_o
);

  // NOTE: assign a default before any conditional in always_comb so no path
  // leaves the output unassigned, which would infer a latch.
  always_comb begin
    blk_o = BLOCK0;
    if (addr_i > 32'(2 * BLOCK_WORDS - 1)) begin
      blk_o = BLOCK2;
    end else if (addr_i > 32'(BLOCK_WORDS - 1)) begin
      blk_o = BLOCK1;
    end
  end

  // Blocks are 64K-aligned, so subtracting block*65536 leaves exactly the
  // low 16 address bits.
  assign offset_o = addr_i[15:0];

endmodule

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Streams 16-bit instruction words from a valid/ready source into a banked
// instruction memory of NUM_BLOCKS blocks of BLOCK_WORDS words each.
// A start in IDLE latches base_addr/word_count; a load that would run past
// the end of memory is rejected with a sticky error and no writes.
// Each accepted beat produces a one-cycle registered write on the next cycle.
//
// Ports:
//   clock       in   1  rising-edge clock
//   reset_n     in   1  asynchronous active-low reset
//   start       in   1  load request, sampled only in IDLE
//   base_addr   in  32  first word address
//   word_count  in  32  number of words to load
//   in_valid    in   1  source word valid
//   in_data     in  16  source word
//   in_ready    out  1  loader accepts a word this cycle (LOAD state)
//   wren        out  3  one-hot block write enable
//   wr_addr     out 16  word offset inside the selected block
//   wr_data     out 16  word to write
//   busy        out  1  high in LOAD
//   done        out  1  one-cycle completion pulse
//   error       out  1  sticky range error, cleared by next accepted start
//   checksum    out 16  running sum of accepted words
//
// Optional feature: define INST_MEM_LOADER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.
// -----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int BLOCK_WORDS = inst_mem_pkg::BLOCK_WORDS,
  parameter int NUM_BLOCKS  = inst_mem_pkg::NUM_BLOCKS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] word_count,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [2:0]  wren,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  import inst_mem_pkg::*;

  localparam logic [32:0] MEM_LIMIT = 33'(NUM_BLOCKS) * 33'(BLOCK_WORDS);

  load_state_e state_q;
  logic [31:0] addr_q;
  logic [31:0] count_q;
  logic [2:0]  wren_q;
  logic [15:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        done_q;
  logic        error_q;

  blk_sel_e    cur_blk;
  logic [15:0] cur_off;
  logic [32:0] end_addr;
  logic        accept;
  logic        start_ok;

  assign accept   = (state_q == LOAD) && in_valid;
  assign start_ok = (state_q == IDLE) && start;
  // Carried in 33 bits so a huge base+count cannot wrap past the check.
  assign end_addr = {1'b0, base_addr} + {1'b0, word_count};

  inst_mem_blk_decode u_blk_decode (
    .addr_i  (addr_q),
    .blk_o   (cur_blk),
    .offset_o(cur_off)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      wren_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      // Write enable and done are single-cycle pulses unless re-armed below.
      wren_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            count_q <= word_count;
            error_q <= 1'b0;
            if (end_addr > MEM_LIMIT) begin
              state_q <= ERR;
            end else if (word_count == 32'd0) begin
              state_q <= DONE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            wren_q    <= blk_onehot(cur_blk);
            wr_addr_q <= cur_off;
            wr_data_q <= in_data;
            addr_q    <= addr_q + 32'd1;
            count_q   <= count_q - 32'd1;
            if (count_q == 32'd1) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // The pulse lands the cycle after the final write.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        ERR: begin
          error_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign wren     = wren_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign error    = error_q;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (start_ok) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + in_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0;
`endif

endmodule
